// File: rtl/mdu_pkg.sv
// Shared MDU types: divider-arbiter FSM states, the latched request record
// and the defined divide-by-zero result.
package mdu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } div_arb_state_e;

    typedef struct packed {
        logic        sgn;
        logic        is_mod;
        logic [31:0] z;
        logic [31:0] d;
    } div_req_t;

    // Quotient and remainder of x / 0 are both defined as zero here.
    localparam logic [31:0] DIV_ZERO_RES = 32'h0;

endpackage

// File: rtl/mdu_div_arbiter_if.sv
// Handshake bundle between the divider arbiter (master) and the shared
// iterative divider (slave).
interface mdu_div_arbiter_if;

    logic        div_valid_o;
    logic        div_ready_i;
    logic        div_signed_o;
    logic [31:0] div_z_o;
    logic [31:0] div_d_o;
    logic        div_res_valid_i;
    logic        div_res_ready_o;
    logic [31:0] div_q_i;
    logic [31:0] div_s_i;
    logic        div_kill_o;

    modport master (
        output div_valid_o, div_signed_o, div_z_o, div_d_o,
               div_res_ready_o, div_kill_o,
        input  div_ready_i, div_res_valid_i, div_q_i, div_s_i
    );

    modport slave (
        input  div_valid_o, div_signed_o, div_z_o, div_d_o,
               div_res_ready_o, div_kill_o,
        output div_ready_i, div_res_valid_i, div_q_i, div_s_i
    );

endinterface

// File: rtl/mdu_prio_grant.sv
// Fixed-priority grant: the lowest set request bit wins. Produces both a
// one-hot grant vector and its encoded index.
module mdu_prio_grant #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top down so the lowest requesting index is written last.
    // NOTE: every output gets a default before the loop, otherwise a
    // combinational block with conditional writes infers latches.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
                idx    = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mdu_div_arbiter.sv
// Shares one external iterative divider between the issue pipes: arbitrates,
// registers operands, sequences the divider handshakes, short-circuits
// divide-by-zero, returns the result to the owning pipe and kills the
// divider when the owner is flushed.
module mdu_div_arbiter
    import mdu_pkg::*;
#(
    parameter int PIPE_NUM = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PIPE_NUM-1:0]      req_valid_i,
    input  logic [PIPE_NUM-1:0]      req_signed_i,
    input  logic [PIPE_NUM-1:0]      req_is_mod_i,
    input  logic [PIPE_NUM-1:0][31:0] req_z_i,
    input  logic [PIPE_NUM-1:0][31:0] req_d_i,
    input  logic [PIPE_NUM-1:0]      stall_i,
    input  logic [PIPE_NUM-1:0]      flush_i,
    output logic [PIPE_NUM-1:0]      busy_o,
    output logic [PIPE_NUM-1:0]      res_valid_o,
    output logic [31:0]              res_o,
    mdu_div_arbiter_if.master        div
);

    localparam int OWNER_W = (PIPE_NUM > 1) ? $clog2(PIPE_NUM) : 1;

    div_arb_state_e       state_q, state_d;
    logic [OWNER_W-1:0]   owner_q;
    div_req_t             req_q;
    logic [31:0]          res_q;
    logic                 kill_q, kill_d;

    logic [PIPE_NUM-1:0]  gnt;
    logic [OWNER_W-1:0]   gnt_idx;
    logic                 gnt_any;
    logic                 gnt_d_zero;
    logic                 owner_flush;
    logic                 load, capture;
    logic                 div_valid, div_res_ready, in_flight;

    // A pipe being flushed this cycle cannot win arbitration.
    mdu_prio_grant #(
        .N     (PIPE_NUM),
        .IDX_W (OWNER_W)
    ) u_grant (
        .req (req_valid_i & ~flush_i),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    assign gnt_any     = |gnt;
    assign gnt_d_zero  = (req_d_i[gnt_idx] == 32'h0);
    assign owner_flush = flush_i[owner_q];
    assign in_flight   = (state_q == ISSUE) || (state_q == WAIT);

    // Next-state and per-state outputs; owner flush overrides everything.
    always_comb begin
        state_d       = state_q;
        load          = 1'b0;
        capture       = 1'b0;
        kill_d        = 1'b0;
        div_valid     = 1'b0;
        div_res_ready = 1'b0;
        res_valid_o   = '0;
        res_o         = '0;
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    load    = 1'b1;
                    state_d = gnt_d_zero ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (owner_flush) begin
                    state_d = IDLE;
                    kill_d  = 1'b1;
                end else begin
                    div_valid = 1'b1;
                    if (div.div_ready_i) state_d = WAIT;
                end
            end
            WAIT: begin
                if (owner_flush) begin
                    state_d = IDLE;
                    kill_d  = 1'b1;
                end else begin
                    div_res_ready = 1'b1;
                    if (div.div_res_valid_i) begin
                        capture = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (owner_flush) begin
                    state_d = IDLE;
                end else begin
                    res_valid_o[owner_q] = 1'b1;
                    res_o                = res_q;
                    if (!stall_i[owner_q]) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, owner, operand and result registers.
    // NOTE: state is written with <= so every register samples the
    // pre-edge values, independent of statement order.
    // NOTE: operands and result are reset too, so the divider-facing outputs
    // and res_o start from a known zero rather than X.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            req_q   <= '0;
            res_q   <= '0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
            if (load) begin
                owner_q      <= gnt_idx;
                req_q.sgn    <= req_signed_i[gnt_idx];
                req_q.is_mod <= req_is_mod_i[gnt_idx];
                req_q.z      <= req_z_i[gnt_idx];
                req_q.d      <= req_d_i[gnt_idx];
                if (gnt_d_zero) res_q <= DIV_ZERO_RES;
            end
            if (capture) begin
                res_q <= req_q.is_mod ? div.div_s_i : div.div_q_i;
            end
        end
    end

    // Stall every active pipe except the owner once its result is ready.
    always_comb begin
        busy_o = req_valid_i & ~flush_i;
        if (state_q == DONE) busy_o[owner_q] = 1'b0;
    end

    assign div.div_valid_o     = div_valid;
    assign div.div_res_ready_o = div_res_ready;
    assign div.div_kill_o      = kill_q;
    assign div.div_signed_o    = req_q.sgn & in_flight;
    assign div.div_z_o         = req_q.z & {32{in_flight}};
    assign div.div_d_o         = req_q.d & {32{in_flight}};

    a_res_onehot : assert property (@(posedge clk) disable iff (rst)
        $onehot0(res_valid_o));
    a_hs_exclusive : assert property (@(posedge clk) disable iff (rst)
        !(div.div_valid_o && div.div_res_ready_o));
    a_kill_single : assert property (@(posedge clk) disable iff (rst)
        div.div_kill_o |=> !div.div_kill_o);

endmodule

// File: tb/tb_mdu_div_arbiter.sv
// Directed bench for mdu_div_arbiter with a 5-cycle divider responder model.
module tb_mdu_div_arbiter;

    localparam int PIPE_NUM = 2;
    localparam int LAT      = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [PIPE_NUM-1:0]       req_valid, req_signed, req_is_mod, stall, flush;
    logic [PIPE_NUM-1:0][31:0] req_z, req_d;
    logic [PIPE_NUM-1:0]       busy, res_valid;
    logic [31:0]               res;

    int n_vec = 0;
    int n_err = 0;

    mdu_div_arbiter_if dif ();

    mdu_div_arbiter #(.PIPE_NUM(PIPE_NUM)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_signed_i (req_signed),
        .req_is_mod_i (req_is_mod),
        .req_z_i      (req_z),
        .req_d_i      (req_d),
        .stall_i      (stall),
        .flush_i      (flush),
        .busy_o       (busy),
        .res_valid_o  (res_valid),
        .res_o        (res),
        .div          (dif)
    );

    always #5 clk = ~clk;

    // Divider responder: accepts, counts LAT cycles, holds result until taken.
    logic        dm_busy = 1'b0;
    logic        dm_rv   = 1'b0;
    logic        late_rv = 1'b0;
    int          dm_cnt  = 0;
    int          dm_accepts = 0;
    logic [31:0] dm_q = '0;
    logic [31:0] dm_s = '0;

    assign dif.div_res_valid_i = dm_rv | late_rv;
    assign dif.div_q_i         = dm_q;
    assign dif.div_s_i         = dm_s;

    always @(posedge clk) begin
        if (rst || dif.div_kill_o) begin
            dm_busy <= 1'b0;
            dm_rv   <= 1'b0;
            dm_cnt  <= 0;
        end else if (dm_rv) begin
            if (dif.div_res_ready_o) begin
                dm_rv   <= 1'b0;
                dm_busy <= 1'b0;
            end
        end else if (dm_busy) begin
            if (dm_cnt == 1) dm_rv <= 1'b1;
            dm_cnt <= dm_cnt - 1;
        end else if (dif.div_valid_o && dif.div_ready_i) begin
            dm_busy    <= 1'b1;
            dm_cnt     <= LAT;
            dm_accepts <= dm_accepts + 1;
            if (dif.div_signed_o) begin
                dm_q <= $signed(dif.div_z_o) / $signed(dif.div_d_o);
                dm_s <= $signed(dif.div_z_o) % $signed(dif.div_d_o);
            end else begin
                dm_q <= dif.div_z_o / dif.div_d_o;
                dm_s <= dif.div_z_o % dif.div_d_o;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int p, input bit sgn, input bit md,
                           input logic [31:0] z, input logic [31:0] d);
        req_valid[p]  = 1'b1;
        req_signed[p] = sgn;
        req_is_mod[p] = md;
        req_z[p]      = z;
        req_d[p]      = d;
    endtask

    // Wait for pipe p's result, check latency/value, optionally stall in DONE,
    // then consume and confirm the result lasted no longer than intended.
    task automatic run_to_result(input int p, input int exp_lat, input logic [31:0] exp_res,
                                 input int hold, input string tag);
        int lat = 99;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (res_valid[p]) begin
                lat = c;
                break;
            end
            check({tag, "_busy_wait"}, 32'(busy), 32'(req_valid & ~flush));
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        if (lat != 99) begin
            check({tag, "_res"}, res, exp_res);
            check({tag, "_res_valid"}, 32'(res_valid), 32'(1) << p);
            check({tag, "_owner_busy"}, 32'(busy[p]), 32'd0);
            for (int h = 0; h < hold; h++) begin
                stall[p] = 1'b1;
                @(negedge clk);
                check({tag, "_hold_valid"}, 32'(res_valid), 32'(1) << p);
                check({tag, "_hold_res"}, res, exp_res);
            end
            stall[p]     = 1'b0;
            req_valid[p] = 1'b0;
            @(negedge clk);
            check({tag, "_after_valid"}, 32'(res_valid), 32'd0);
            check({tag, "_after_res"}, res, 32'd0);
            check({tag, "_after_div_valid"}, 32'(dif.div_valid_o), 32'd0);
            check({tag, "_after_busy"}, 32'(busy), 32'(req_valid));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        req_valid = '0; req_signed = '0; req_is_mod = '0;
        req_z = '0; req_d = '0; stall = '0; flush = '0;
        dif.div_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset / idle state.
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res", res, 32'd0);
        check("rst_div_valid", 32'(dif.div_valid_o), 32'd0);
        check("rst_res_ready", 32'(dif.div_res_ready_o), 32'd0);
        check("rst_kill", 32'(dif.div_kill_o), 32'd0);
        check("rst_div_z", dif.div_z_o, 32'd0);

        // Single signed mod: -7 % 2 = -1.
        set_req(0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
        #1 check("t1_busy_idle", 32'(busy), 32'd1);
        @(negedge clk);
        check("t1_div_valid", 32'(dif.div_valid_o), 32'd1);
        check("t1_div_z", dif.div_z_o, 32'hFFFF_FFF9);
        check("t1_div_d", dif.div_d_o, 32'd2);
        check("t1_div_signed", 32'(dif.div_signed_o), 32'd1);
        run_to_result(0, 7, 32'hFFFF_FFFF, 0, "t1");

        // Contention: 100/7 on pipe0 wins, then 9%4 on pipe1.
        set_req(0, 1'b0, 1'b0, 32'd100, 32'd7);
        set_req(1, 1'b0, 1'b1, 32'd9, 32'd4);
        run_to_result(0, 8, 32'd14, 0, "t2p0");
        run_to_result(1, 8, 32'd1, 0, "t2p1");

        // Divide by zero on pipe1: no divider access, result 0 next cycle.
        acc = dm_accepts;
        set_req(1, 1'b0, 1'b0, 32'd5, 32'd0);
        run_to_result(1, 1, 32'd0, 0, "t3");
        check("t3_no_div_access", 32'(dm_accepts), 32'(acc));

        // Owner flush in WAIT, pipe1 pending.
        set_req(0, 1'b0, 1'b0, 32'd50, 32'd5);
        set_req(1, 1'b0, 1'b1, 32'd22, 32'd5);
        @(negedge clk);
        check("t4_issue", 32'(dif.div_valid_o), 32'd1);
        repeat (3) @(negedge clk);
        flush[0] = 1'b1;
        #1 check("t4_flush_busy", 32'(busy), 32'd2);
        check("t4_no_kill_yet", 32'(dif.div_kill_o), 32'd0);
        @(negedge clk);
        flush[0] = 1'b0;
        req_valid[0] = 1'b0;
        check("t4_kill", 32'(dif.div_kill_o), 32'd1);
        check("t4_no_res", 32'(res_valid), 32'd0);
        check("t4_idle_div_valid", 32'(dif.div_valid_o), 32'd0);
        check("t4_idle_res_ready", 32'(dif.div_res_ready_o), 32'd0);
        @(negedge clk);
        check("t4_kill_single", 32'(dif.div_kill_o), 32'd0);
        check("t4_p1_issue", 32'(dif.div_valid_o), 32'd1);
        check("t4_p1_z", dif.div_z_o, 32'd22);
        run_to_result(1, 7, 32'd2, 0, "t4p1");

        // Stall hold in DONE for 3 cycles: 45/6 = 7.
        set_req(0, 1'b0, 1'b0, 32'd45, 32'd6);
        run_to_result(0, 8, 32'd7, 3, "t5");

        // Reset in WAIT, then a late divider result must be ignored.
        set_req(0, 1'b0, 1'b0, 32'd81, 32'd9);
        repeat (2) @(negedge clk);
        check("t6_in_wait", 32'(dif.div_res_ready_o), 32'd1);
        rst = 1'b1;
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_res_valid", 32'(res_valid), 32'd0);
        check("t6_res", res, 32'd0);
        check("t6_div_valid", 32'(dif.div_valid_o), 32'd0);
        check("t6_res_ready", 32'(dif.div_res_ready_o), 32'd0);
        check("t6_kill", 32'(dif.div_kill_o), 32'd0);
        check("t6_div_z", dif.div_z_o, 32'd0);
        check("t6_div_d", dif.div_d_o, 32'd0);
        late_rv = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t6_late_res_valid", 32'(res_valid), 32'd0);
            check("t6_late_res_ready", 32'(dif.div_res_ready_o), 32'd0);
        end
        late_rv = 1'b0;

        // Fresh signed divide after reset: -100/7 = -14.
        set_req(1, 1'b1, 1'b0, 32'hFFFF_FF9C, 32'd7);
        run_to_result(1, 8, 32'hFFFF_FFF2, 0, "t7");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
